uart_autobaud: RTL and testbench

- Auto-baud controller that configures the `prescale` input of `uart_rx`, and optionally `uart_tx`.
- When armed, it waits for an idle line, then times a 0x55 sync character on rxd. Framed 8N1 LSB-first, 0x55 gives a line toggling every bit time.
- It computes prescale = bit_time/8, rounded, and holds the result on its output until the next successful calibration.
- Sits between the rxd pin and the UART config inputs; it does not touch the UART data path.

---
 rtl/uart_autobaud.sv | 259 +++++++++++++++++++++++++
 tb/tb_uart_autobaud.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_autobaud.sv
// uart_autobaud: times a 0x55 sync character on rxd and derives the
// uart prescale (clocks per bit / 8, rounded) for uart_rx / uart_tx.
//
// Parameters:
//   PRESCALE_WIDTH   width of prescale output
//   COUNT_WIDTH      width of segment / total counters (saturation = timeout)
//   IDLE_CYCLES      high cycles required before start-edge detection
//   DEFAULT_PRESCALE prescale value after reset
// Ports:
//   clk      clock, rising edge
//   rst      synchronous active-high reset
//   rxd      asynchronous serial line, idle high
//   start    single-cycle arm pulse (ignored while busy)
//   prescale calibrated prescale
//   locked   prescale holds a calibrated value
//   busy     controller is not idle
//   error    one-cycle pulse on a failed calibration
// Optional: define UART_AUTOBAUD_STOP_CHECK_EN to also validate the last
// data bit and the stop bit before accepting a result.

module uart_autobaud #(
  parameter int PRESCALE_WIDTH = 16,
  parameter int COUNT_WIDTH    = 24,
  parameter int IDLE_CYCLES    = 64,
  parameter logic [PRESCALE_WIDTH-1:0] DEFAULT_PRESCALE = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rxd,
  input  logic                      start,
  output logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      locked,
  output logic                      busy,
  output logic                      error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IDLE,
    S_WAIT_START,
    S_MEAS_FIRST,
    S_MEASURE,
    S_STOP_CHECK,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE =
    COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] IDLE_TGT =
    COUNT_WIDTH'(IDLE_CYCLES);
  localparam logic [PRESCALE_WIDTH-1:0] PS_MAX = '1;

  state_t state_q, state_d;

  logic rxd_s1_q, rxd_s2_q, rxd_d1_q;

  logic [COUNT_WIDTH-1:0] seg_q, seg_d;
  logic [COUNT_WIDTH-1:0] total_q, total_d;
  logic [COUNT_WIDTH-1:0] w0_q, w0_d;
  logic [2:0]             edge_cnt_q, edge_cnt_d;

  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic                      locked_q, locked_d;
  logic                      busy_q, error_q;

`ifdef UART_AUTOBAUD_STOP_CHECK_EN
  logic stop_hi_q, stop_hi_d;
`endif

  logic rx_edge, rx_fall;
  logic sat;
  logic tol_ok;
  logic signed [COUNT_WIDTH:0] diff, tol;
  logic [COUNT_WIDTH:0] r_full;
  logic [COUNT_WIDTH-1:0] seg_inc, total_inc;

  assign rx_edge   = rxd_s2_q ^ rxd_d1_q;
  assign rx_fall   = rxd_d1_q & ~rxd_s2_q;
  assign sat       = (seg_q == CNT_MAX) || (total_q == CNT_MAX);
  assign seg_inc   = seg_q + CNT_ONE;
  assign total_inc = total_q + CNT_ONE;

  // Segment must sit within w0 +/- w0/4; one extra bit keeps the
  // difference signed without wrap-around.
  always_comb begin
    diff   = $signed({1'b0, seg_q}) - $signed({1'b0, w0_q});
    tol    = $signed({1'b0, w0_q >> 2});
    tol_ok = (diff <= tol) && (diff >= -tol);
  end

  // total spans 8 bit times; /64 gives bit_time/8, +32 rounds.
  assign r_full = ({1'b0, total_q} + (COUNT_WIDTH+1)'(32)) >> 6;

  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    total_d    = total_q;
    w0_d       = w0_q;
    edge_cnt_d = edge_cnt_q;
    prescale_d = prescale_q;
    locked_d   = locked_q;
`ifdef UART_AUTOBAUD_STOP_CHECK_EN
    stop_hi_d  = stop_hi_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_WAIT_IDLE;
          locked_d = 1'b0;
          seg_d    = '0;
        end
      end
      S_WAIT_IDLE: begin
        if (!rxd_s2_q) begin
          seg_d = '0;
        end else if (seg_inc >= IDLE_TGT) begin
          seg_d   = '0;
          state_d = S_WAIT_START;
        end else begin
          seg_d = seg_inc;
        end
      end
      S_WAIT_START: begin
        if (rx_fall) begin
          state_d = S_MEAS_FIRST;
          seg_d   = CNT_ONE;
          total_d = CNT_ONE;
        end
      end
      S_MEAS_FIRST: begin
        if (sat) begin
          state_d = S_FAIL;
        end else if (rx_edge) begin
          w0_d       = seg_q;
          seg_d      = CNT_ONE;
          total_d    = total_inc;
          edge_cnt_d = 3'd1;
          state_d    = S_MEASURE;
        end else begin
          seg_d   = seg_inc;
          total_d = total_inc;
        end
      end
      S_MEASURE: begin
        if (sat) begin
          state_d = S_FAIL;
        end else if (rx_edge) begin
          if (!tol_ok) begin
            state_d = S_FAIL;
          end else if (edge_cnt_q == 3'd7) begin
            // total is frozen here at exactly 8 bit times
`ifdef UART_AUTOBAUD_STOP_CHECK_EN
            state_d   = S_STOP_CHECK;
            seg_d     = CNT_ONE;
            stop_hi_d = 1'b0;
`else
            state_d = S_DONE;
`endif
          end else begin
            edge_cnt_d = edge_cnt_q + 3'd1;
            seg_d      = CNT_ONE;
            total_d    = total_inc;
          end
        end else begin
          seg_d   = seg_inc;
          total_d = total_inc;
        end
      end
`ifdef UART_AUTOBAUD_STOP_CHECK_EN
      S_STOP_CHECK: begin
        if (seg_q == CNT_MAX) begin
          state_d = S_FAIL;
        end else if (!stop_hi_q) begin
          // bit 7 low segment, closed by the rising edge
          if (rx_edge) begin
            if (!tol_ok) begin
              state_d = S_FAIL;
            end else begin
              stop_hi_d = 1'b1;
              seg_d     = CNT_ONE;
            end
          end else begin
            seg_d = seg_inc;
          end
        end else if (rx_edge) begin
          state_d = S_FAIL;
        end else if (seg_q >= w0_q) begin
          state_d = S_DONE;
        end else begin
          seg_d = seg_inc;
        end
      end
`endif
      S_DONE: begin
        if (r_full == '0) begin
          state_d = S_FAIL;
        end else begin
          if (r_full > (COUNT_WIDTH+1)'(PS_MAX)) begin
            prescale_d = PS_MAX;
          end else begin
            prescale_d = PRESCALE_WIDTH'(r_full);
          end
          locked_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_FAIL: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_d1_q   <= 1'b1;
      seg_q      <= '0;
      total_q    <= '0;
      w0_q       <= '0;
      edge_cnt_q <= '0;
      prescale_q <= DEFAULT_PRESCALE;
      locked_q   <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef UART_AUTOBAUD_STOP_CHECK_EN
      stop_hi_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rxd_s1_q   <= rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_d1_q   <= rxd_s2_q;
      seg_q      <= seg_d;
      total_q    <= total_d;
      w0_q       <= w0_d;
      edge_cnt_q <= edge_cnt_d;
      prescale_q <= prescale_d;
      locked_q   <= locked_d;
      busy_q     <= (state_d != S_IDLE);
      error_q    <= (state_d == S_FAIL);
`ifdef UART_AUTOBAUD_STOP_CHECK_EN
      stop_hi_q  <= stop_hi_d;
`endif
    end
  end

  assign prescale = prescale_q;
  assign locked   = locked_q;
  assign busy     = busy_q;
  assign error    = error_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// tb_uart_autobaud: directed and randomized frames checked against a
// run-length model of the sync character timing.

module tb_uart_autobaud;

  typedef int bl_t[10];

  logic        clk = 1'b0;
  logic        rst;
  logic        rxd;
  logic        start;
  logic [15:0] prescale;
  logic        locked;
  logic        busy;
  logic        error;

  int total = 0;
  int bad = 0;
  int err_cnt = 0;

  logic [15:0] exp_ps;
  logic        exp_lk;

  uart_autobaud dut (
    .clk(clk),
    .rst(rst),
    .rxd(rxd),
    .start(start),
    .prescale(prescale),
    .locked(locked),
    .busy(busy),
    .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (error === 1'b1) err_cnt++;
  endtask

  function automatic bl_t uni(input int b);
    bl_t a;
    for (int i = 0; i < 10; i++) a[i] = b;
    return a;
  endfunction

  // kind: 0 = lock with prescale r, 1 = error, 2 = never completes.
  // The frame is reduced to line run lengths; the run holding the stop
  // bit merges into the idle line and never ends.
  function automatic void predict(input logic [7:0] d, input bl_t bl,
                                  output int kind, output int r);
    int runs[$];
    logic [9:0] fr;
    int cur, w0, tot, df;
    fr = {1'b1, d, 1'b0};
    cur = bl[0];
    for (int i = 1; i < 10; i++) begin
      if (fr[i] == fr[i-1]) cur += bl[i];
      else begin
        runs.push_back(cur);
        cur = bl[i];
      end
    end
    kind = 0;
    r = 0;
    w0 = runs[0];
    tot = w0;
    for (int k = 1; k < 8; k++) begin
      if (k >= runs.size()) begin
        kind = 2;
        return;
      end
      df = runs[k] - w0;
      if (df < 0) df = -df;
      if (df > w0 / 4) begin
        kind = 1;
        return;
      end
      tot += runs[k];
    end
    r = (tot + 32) / 64;
    if (r == 0) kind = 1;
    else if (r > 65535) r = 65535;
  endfunction

  task automatic arm();
    err_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    rxd = 1'b1;
    repeat (100) step();
  endtask

  // mode 1: extra start pulse mid-frame; mode 2: reset mid-frame
  task automatic send(input logic [7:0] d, input bl_t bl,
                      input int mode);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      for (int c = 0; c < bl[i]; c++) begin
        if (c == 0 && i == 3 && mode == 1) start = 1'b1;
        if (c == 0 && i == 4 && mode == 2) rst = 1'b1;
        step();
        start = 1'b0;
        rst = 1'b0;
      end
    end
    rxd = 1'b1;
  endtask

  task automatic run_case(input string tag, input logic [7:0] d,
                          input bl_t bl, input int mode);
    int kind, r, n, exp_err;
    predict(d, bl, kind, r);
    send(d, bl, mode);
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      step();
      n++;
    end
    chk({tag, "_busy"}, busy, 0);
    repeat (4) step();
    if (mode == 2) begin
      exp_ps = 16'd0;
      exp_lk = 1'b0;
      exp_err = 0;
    end else if (kind == 0) begin
      exp_ps = r[15:0];
      exp_lk = 1'b1;
      exp_err = 0;
    end else begin
      exp_lk = 1'b0;
      exp_err = 1;
    end
    chk({tag, "_prescale"}, prescale, exp_ps);
    chk({tag, "_locked"}, locked, exp_lk);
    chk({tag, "_errpulse"}, err_cnt, exp_err);
  endtask

  initial begin
    int b, j, kind, r;
    logic [7:0] d;
    bl_t bl;

    rst = 1'b1;
    rxd = 1'b1;
    start = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_prescale", prescale, 0);
    chk("rst_locked", locked, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    exp_ps = 16'd0;
    exp_lk = 1'b0;

    arm();
    chk("armed_busy", busy, 1);
    run_case("b32", 8'h55, uni(32), 0);
    chk("b32_const", prescale, 4);

    arm();
    run_case("b100", 8'h55, uni(100), 0);
    chk("b100_const", prescale, 13);

    arm();
    run_case("b32_again", 8'h55, uni(32), 0);
    arm();
    run_case("x0f", 8'h0F, uni(32), 0);
    chk("x0f_const", prescale, 4);

    arm();
    run_case("b3", 8'h55, uni(3), 0);
    chk("b3_const", prescale, 4);
    arm();
    run_case("b6", 8'h55, uni(6), 0);
    chk("b6_const", prescale, 1);

    rxd = 1'b0;
    err_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (1000) step();
    chk("break_busy", busy, 1);
    chk("break_err", err_cnt, 0);
    rxd = 1'b1;
    repeat (100) step();
    run_case("after_break", 8'h55, uni(32), 0);
    chk("after_break_const", prescale, 4);

    arm();
    run_case("restart_ign", 8'h55, uni(32), 1);
    chk("restart_const", prescale, 4);

    arm();
    run_case("rst_mid", 8'h55, uni(32), 2);

    for (int it = 0; it < 12; it++) begin
      b = $urandom_range(120, 4);
      j = $urandom_range(b / 3, 0);
      for (int i = 0; i < 10; i++) begin
        bl[i] = b + $urandom_range(2 * j, 0) - j;
        if (bl[i] < 1) bl[i] = 1;
      end
      d = ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'h55;
      predict(d, bl, kind, r);
      if (kind == 2) d = 8'h55;
      arm();
      run_case($sformatf("rnd%0d", it), d, bl, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
